sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO and successor of the fixed 8x8 FIFO: generic data width and depth.
- Adds full, empty and occupancy outputs, and supports a read and a write in the same cycle, including when full.
- Used as the standard buffering block between producer and consumer stages in the lab designs.

Parameters:
- WIDTH, 8, data bit width (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset; one clock, reset sampled on clk rising edge.
- wen  in  1  write request.
- ren  in  1  read request.
- din  in  WIDTH  write data, sampled on clk when wen=1.
- dout  out  WIDTH  registered read data.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  AW+1  occupancy, 0..DEPTH.
- error  out  1  registered; high for the cycle after an illegal request.

Behaviour:
- Reset (rst=1 at an edge), regardless of wen/ren:
  - rptr=wptr=0, count=0, dout=0, error=0; empty=1, full=0.
  - Memory contents are not cleared but are unreachable.
  - Reset mid-operation discards all stored data.
- Flags: full and empty are decoded from the registered count and are valid in the same cycle as count.
- Write accepted when wen=1 and (!full or ren=1):
  - mem[wptr]<=din; wptr<=wptr+1 mod DEPTH.
- Read accepted when ren=1 and !empty:
  - dout<=mem[rptr] at that edge, so data is visible the cycle after the request (1-cycle latency).
  - rptr<=rptr+1 mod DEPTH.
- Count update: +1 for write only, -1 for read only, unchanged for both or neither.
- Simultaneous cases:
  - Not empty, not full: both performed, count unchanged.
  - Full with wen=ren=1: read of oldest entry and write both performed, count stays DEPTH, no error.
  - Empty with wen=ren=1: write performed, read rejected (no bypass of din to dout), count becomes 1, error=1.
- Illegal requests:
  - ren=1 while empty (underflow).
  - wen=1 while full and ren=0 (overflow).
  - Either sets error=1 for exactly the following cycle. A rejected request changes no pointer, count or memory.
- dout holds its last value on any cycle without an accepted read, including on error.
- Pointer wrap: natural AW-bit overflow; no extra wrap bit, since count disambiguates full from empty.
- Priority: rst over everything; no other priority is needed because reads and writes are independent.

Optional Feature:
- Macro: SYNC_FIFO_ALMOST_EN.
- Defined:
  - Adds parameters AF_MARGIN (default 1) and AE_MARGIN (default 1).
  - Adds output almost_full = (count >= DEPTH-AF_MARGIN).
  - Adds output almost_empty = (count <= AE_MARGIN).
  - Both decoded from registered count; reset values almost_full=0, almost_empty=1.
- Undefined: these ports and parameters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - the pointer-width function used to derive AW;
  - a localparam for the count width (AW+1);
  - the error-cause encodings ERR_NONE, ERR_UNDERFLOW, ERR_OVERFLOW, used by the bench scoreboard.
- One sub-module fifo_ram: WIDTH x DEPTH register array with a synchronous write port and a synchronous read port.
  - Read port output is the dout register.
  - Its read-enable is the accepted-read strobe.
  - Top level holds pointers, count, flags and error.

Test Plan (WIDTH=8, DEPTH=8):
- Fill: after reset, write 56,11,42,10,23,20,6,85 on consecutive cycles -> count=8, full=1, empty=0, error=0 throughout.
- Overflow: while full, wen=1 din=45 ren=0 -> error=1 next cycle then 0; count stays 8; a later drain still yields 56 first.
- Drain/underflow: read 8 times -> dout 56,11,42,10,23,20,6,85, each one cycle after its request; empty=1; a ninth read -> error=1, dout holds 85.
- Full read+write: full with 56..85, wen=ren=1 din=77 -> dout=56, count=8, no error; a full drain ends with 77 last.
- Empty read+write: empty, wen=ren=1 din=12 -> error=1, count=1, dout unchanged; the next read returns 12.
- Wrap and reset: write 5, read 5, write 6 (pointers wrap) -> data emerges in order; assert rst with count=4 -> next cycle count=0, empty=1, dout=0, error=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers for sync_fifo_param: pointer-width function,
//               default count width and error-cause encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Pointer width for a power-of-two depth; a depth of 1 still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int FIFO_AW_DEF    = ptr_width(FIFO_DEPTH_DEF);
    localparam int FIFO_CW_DEF    = FIFO_AW_DEF + 1;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2
    } err_cause_e;

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : WIDTH x DEPTH register array, synchronous write port and a
//               registered read port whose output register is the FIFO dout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; the pointers make stale data unreachable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised synchronous FIFO with full/empty/count and a
//               registered error flag. Optional SYNC_FIFO_ALMOST_EN adds
//               almost_full/almost_empty outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH_DEF
`ifdef SYNC_FIFO_ALMOST_EN
    ,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wen,
    input  logic                        ren,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [ptr_width(DEPTH):0]   count,
`ifdef SYNC_FIFO_ALMOST_EN
    output logic                        almost_full,
    output logic                        almost_empty,
`endif
    output logic                        error
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          error_q;
    err_cause_e    cause_d;
    logic          wr_accept;
    logic          rd_accept;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        // Reading frees a slot in the same edge, so a full FIFO still takes a write.
        wr_accept = wen && (!full || ren);
        rd_accept = ren && !empty;

        wptr_d  = wr_accept ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd_accept ? rptr_q + AW'(1) : rptr_q;

        count_d = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        cause_d = ERR_NONE;
        if (ren && empty) begin
            cause_d = ERR_UNDERFLOW;
        end else if (wen && full && !ren) begin
            cause_d = ERR_OVERFLOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            error_q <= (cause_d != ERR_NONE);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_accept),
        .waddr_i (wptr_q),
        .wdata_i (din),
        .re_i    (rd_accept),
        .raddr_i (rptr_q),
        .rdata_o (dout)
    );

    assign count = count_q;
    assign error = error_q;

`ifdef SYNC_FIFO_ALMOST_EN
    assign almost_full  = (int'(count_q) >= (DEPTH - AF_MARGIN));
    assign almost_empty = (int'(count_q) <= AE_MARGIN);
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed self-checking bench for sync_fifo_param (8x8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;
    import fifo_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wen;
    logic                   ren;
    logic [7:0]             din;
    logic [7:0]             dout;
    logic                   full;
    logic                   empty;
    logic [FIFO_CW_DEF-1:0] count;
    logic                   error;
`ifdef SYNC_FIFO_ALMOST_EN
    logic                   almost_full;
    logic                   almost_empty;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fill_v  [8] = '{8'd56, 8'd11, 8'd42, 8'd10, 8'd23, 8'd20, 8'd6, 8'd85};
    logic [7:0] rw_v    [8] = '{8'd11, 8'd42, 8'd10, 8'd23, 8'd20, 8'd6, 8'd85, 8'd77};
    logic [7:0] wrap5_v [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [7:0] wrap6_v [6] = '{8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106};

    sync_fifo_param #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen),
        .ren          (ren),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .count        (count),
`ifdef SYNC_FIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] err_of(input err_cause_e c);
        return (c != ERR_NONE) ? 32'd1 : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1; ren = 1'b0; din = fill_v[i];
            tick();
            check("fill_err", error, err_of(ERR_NONE));
            check("fill_cnt", count, i + 1);
            check("fill_empty", empty, 0);
        end
        wen = 1'b0;
        check("fill_full", full, 1);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; din = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_cnt", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_err", error, 0);
        check("rst_dout", dout, 0);

        fill();

        // Overflow: rejected write, error for one cycle only
        wen = 1'b1; din = 8'd45;
        tick();
        check("ovf_err", error, err_of(ERR_OVERFLOW));
        check("ovf_cnt", count, 8);
        wen = 1'b0;
        tick();
        check("ovf_err_clr", error, 0);
        check("ovf_cnt2", count, 8);

        // Drain in order, then underflow
        for (int i = 0; i < 8; i++) begin
            ren = 1'b1;
            tick();
            check("drain_dout", dout, fill_v[i]);
            check("drain_err", error, 0);
            check("drain_cnt", count, 7 - i);
        end
        check("drain_empty", empty, 1);
        tick();
        check("unf_err", error, err_of(ERR_UNDERFLOW));
        check("unf_dout", dout, 85);
        check("unf_cnt", count, 0);
        ren = 1'b0;
        tick();
        check("unf_err_clr", error, 0);

        // Simultaneous read+write while full
        fill();
        wen = 1'b1; ren = 1'b1; din = 8'd77;
        tick();
        check("frw_dout", dout, 56);
        check("frw_cnt", count, 8);
        check("frw_err", error, 0);
        check("frw_full", full, 1);
        wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("frw_drain", dout, rw_v[i]);
        end
        ren = 1'b0;
        check("frw_empty", empty, 1);

        // Simultaneous read+write while empty: write only, no bypass
        wen = 1'b1; ren = 1'b1; din = 8'd12;
        tick();
        check("erw_err", error, err_of(ERR_UNDERFLOW));
        check("erw_cnt", count, 1);
        check("erw_dout", dout, 77);
        wen = 1'b0;
        tick();
        check("erw_rd", dout, 12);
        check("erw_rd_err", error, 0);
        check("erw_rd_cnt", count, 0);
        ren = 1'b0;

        // Pointer wrap
        for (int i = 0; i < 5; i++) begin
            wen = 1'b1; din = wrap5_v[i];
            tick();
        end
        wen = 1'b0;
        check("wrap_cnt5", count, 5);
        for (int i = 0; i < 5; i++) begin
            ren = 1'b1;
            tick();
            check("wrap_rd5", dout, wrap5_v[i]);
        end
        ren = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wen = 1'b1; din = wrap6_v[i];
            tick();
        end
        wen = 1'b0;
        check("wrap_cnt6", count, 6);
        for (int i = 0; i < 2; i++) begin
            ren = 1'b1;
            tick();
            check("wrap_rd6", dout, wrap6_v[i]);
        end
        ren = 1'b0;
        check("wrap_cnt4", count, 4);

        // Reset mid-operation with requests active
        rst = 1'b1; wen = 1'b1; ren = 1'b1; din = 8'd99;
        tick();
        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        check("mrst_cnt", count, 0);
        check("mrst_empty", empty, 1);
        check("mrst_full", full, 0);
        check("mrst_dout", dout, 0);
        check("mrst_err", error, 0);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("mrst_unf", error, 1);
        check("mrst_unf_dout", dout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
